// File: rtl/timer_regif_if.sv
// Single-beat memory-mapped bus between the peripheral decoder (master) and timer_regif (slave).
interface timer_regif_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              bus_sel;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_sel,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_sel,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ready
    );
endinterface

// File: rtl/timer_regif.sv
// timer_regif: CPU-facing register front end driving the ro_*/rf_* interface of the timing block.
// Optional macro TIMER_SNAPSHOT_EN: STATUS reads latch rf_currcount so CURRCOUNT reads are coherent.
module timer_regif #(
    parameter int unsigned ADDR_W   = 4,
    parameter logic [31:0] TERM_RST = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    timer_regif_if.slave bus,
    output logic         ro_trig_start,
    output logic         ro_trig_halt,
    output logic [31:0]  ro_termcount,
    input  logic         rf_status,
    input  logic [31:0]  rf_currcount,
    input  logic         rf_int,
    output logic         irq
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TERM   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CURR   = 2'd3;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        word_sel;
    logic              unused_addr_bits;

    logic              wr_ctrl;
    logic              wr_term;
    logic              wr_status;
    logic              rd_access;
    logic              rd_status;
    logic              int_edge;

    logic [31:0]       curr_rd;
    logic [31:0]       rd_val;

    logic              ready_q,  ready_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              start_q,  start_d;
    logic              halt_q,   halt_d;
    logic              ie_q,     ie_d;
    logic [31:0]       term_q,   term_d;
    logic              pend_q,   pend_d;
    logic              int_prev_q;

    // Only the word index matters; byte-lane bits and any widened upper bits alias onto the map.
    assign addr             = bus.bus_addr;
    assign word_sel         = addr[3:2];
    assign unused_addr_bits = ^addr;

    assign wr_ctrl   = bus.bus_sel &  bus.bus_we & (word_sel == REG_CTRL);
    assign wr_term   = bus.bus_sel &  bus.bus_we & (word_sel == REG_TERM);
    assign wr_status = bus.bus_sel &  bus.bus_we & (word_sel == REG_STATUS);
    assign rd_access = bus.bus_sel & ~bus.bus_we;
    assign rd_status = rd_access & (word_sel == REG_STATUS);
    assign int_edge  = rf_int & ~int_prev_q;

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (rd_status) begin
            snap_d = rf_currcount;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q <= 32'h0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign curr_rd = snap_q;
`else
    assign curr_rd = rf_currcount;
`endif

    always_comb begin
        rd_val = 32'h0;
        case (word_sel)
            REG_CTRL:   rd_val = {29'b0, ie_q, 2'b00};
            REG_TERM:   rd_val = term_q;
            REG_STATUS: rd_val = {30'b0, pend_q, rf_status};
            REG_CURR:   rd_val = curr_rd;
            default:    rd_val = 32'h0;
        endcase
    end

    always_comb begin
        ready_d = bus.bus_sel;
        rdata_d = rd_access ? rd_val : 32'h0;

        // Halt dominates when software sets both trigger bits in one write.
        start_d = wr_ctrl & bus.bus_wdata[0] & ~bus.bus_wdata[1];
        halt_d  = wr_ctrl & bus.bus_wdata[1];
        ie_d    = wr_ctrl ? bus.bus_wdata[2] : ie_q;
        term_d  = wr_term ? bus.bus_wdata : term_q;

        // A fresh rf_int edge beats a simultaneous W1C so no event is lost.
        pend_d = pend_q;
        if (wr_status && bus.bus_wdata[1]) begin
            pend_d = 1'b0;
        end
        if (int_edge) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            start_q    <= 1'b0;
            halt_q     <= 1'b0;
            ie_q       <= 1'b0;
            term_q     <= TERM_RST;
            pend_q     <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            halt_q     <= halt_d;
            ie_q       <= ie_d;
            term_q     <= term_d;
            pend_q     <= pend_d;
            int_prev_q <= rf_int;
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign ro_trig_start = start_q;
    assign ro_trig_halt  = halt_q;
    assign ro_termcount  = term_q;
    assign irq           = pend_q & ie_q;
endmodule

// File: tb/tb_timer_regif.sv
// Self-checking bench for timer_regif: directed scenarios plus a randomized run against a register-level model.
module tb_timer_regif;
    localparam logic [31:0] TERM_RST = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic [31:0] ro_termcount;
    logic        irq;

    int total;
    int bad;

    timer_regif_if #(.ADDR_W(4)) bus_if ();

    timer_regif #(.ADDR_W(4), .TERM_RST(TERM_RST)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if.slave),
        .ro_trig_start(ro_trig_start),
        .ro_trig_halt (ro_trig_halt),
        .ro_termcount (ro_termcount),
        .rf_status    (rf_status),
        .rf_currcount (rf_currcount),
        .rf_int       (rf_int),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic bus_xfer(input logic we, input logic [3:0] a, input logic [31:0] wd,
                            output logic rdy, output logic [31:0] rd);
        bus_if.bus_sel   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = wd;
        @(posedge clk); #1;
        bus_if.bus_sel   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = 4'h0;
        bus_if.bus_wdata = 32'h0;
        rdy = bus_if.bus_ready;
        rd  = bus_if.bus_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rf_int = 1'b0;
        bus_if.bus_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ro_termcount !== TERM_RST) begin bad++; $display("FAIL rst_term: got %h want %h", ro_termcount, TERM_RST); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
        total++; if (bus_if.bus_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus_if.bus_ready); end
        total++; if ({ro_trig_start, ro_trig_halt} !== 2'b00) begin bad++; $display("FAIL rst_trig: got %b want 00", {ro_trig_start, ro_trig_halt}); end
        total++; if (bus_if.bus_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus_if.bus_rdata); end
        reset = 1'b1;
        idle();
        total++; if (bus_if.bus_ready !== 1'b0 || ro_termcount !== TERM_RST) begin bad++; $display("FAIL rst_release: got rdy=%b term=%h want 0 %h", bus_if.bus_ready, ro_termcount, TERM_RST); end
    endtask

    task automatic test_program_start();
        logic rdy; logic [31:0] rd;
        bus_xfer(1'b1, 4'h4, 32'd100, rdy, rd);
        total++; if (ro_termcount !== 32'd100) begin bad++; $display("FAIL prog_term: got %0d want 100", ro_termcount); end
        total++; if (rdy !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL prog_wack: got rdy=%b rd=%h want 1 0", rdy, rd); end
        bus_xfer(1'b1, 4'h0, 32'h5, rdy, rd);
        total++; if (ro_trig_start !== 1'b1 || ro_trig_halt !== 1'b0) begin bad++; $display("FAIL start_pulse: got s=%b h=%b want 1 0", ro_trig_start, ro_trig_halt); end
        idle();
        total++; if (ro_trig_start !== 1'b0) begin bad++; $display("FAIL start_width: got %b want 0", ro_trig_start); end
        total++; if (bus_if.bus_ready !== 1'b0) begin bad++; $display("FAIL ready_drop: got %b want 0", bus_if.bus_ready); end
        bus_xfer(1'b0, 4'h0, 32'h0, rdy, rd);
        total++; if (rdy !== 1'b1 || rd !== 32'h4) begin bad++; $display("FAIL ctrl_read: got rdy=%b rd=%h want 1 4", rdy, rd); end
    endtask

    task automatic test_simultaneous();
        logic rdy; logic [31:0] rd;
        bus_xfer(1'b1, 4'h0, 32'h3, rdy, rd);
        total++; if (ro_trig_halt !== 1'b1 || ro_trig_start !== 1'b0) begin bad++; $display("FAIL halt_wins: got s=%b h=%b want 0 1", ro_trig_start, ro_trig_halt); end
        idle();
        total++; if (ro_trig_halt !== 1'b0) begin bad++; $display("FAIL halt_width: got %b want 0", ro_trig_halt); end
    endtask

    task automatic test_interrupt();
        logic rdy; logic [31:0] rd;
        rf_status = 1'b1;
        bus_xfer(1'b1, 4'h0, 32'h4, rdy, rd);
        rf_int = 1'b1;
        idle();
        rf_int = 1'b0;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL status_rd: got %h want 3", rd); end
        bus_xfer(1'b1, 4'h0, 32'h0, rdy, rd);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_mask: got %b want 0", irq); end
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL mask_keeps_pend: got %h want 3", rd); end
        bus_xfer(1'b1, 4'h0, 32'h4, rdy, rd);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_unmask: got %b want 1", irq); end
        bus_xfer(1'b1, 4'h8, 32'h1, rdy, rd);
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL w1c_bit0_ignored: got %h want 3", rd); end
        bus_xfer(1'b1, 4'h8, 32'h2, rdy, rd);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL w1c_clear: got %h want 1", rd); end
        bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 4'h8; bus_if.bus_wdata = 32'h2;
        rf_int = 1'b1;
        idle();
        bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
        rf_int = 1'b0;
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL set_beats_w1c: got %h want 3", rd); end
        bus_xfer(1'b1, 4'h8, 32'h2, rdy, rd);
        bus_xfer(1'b1, 4'h0, 32'h0, rdy, rd);
        rf_status = 1'b0;
    endtask

    task automatic test_read_path();
        logic rdy; logic [31:0] rd;
        rf_currcount = 32'hDEAD_BEEF;
`ifdef TIMER_SNAPSHOT_EN
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
`endif
        bus_xfer(1'b0, 4'hC, 32'h0, rdy, rd);
        total++; if (rdy !== 1'b1 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL curr_read: got rdy=%b rd=%h want 1 deadbeef", rdy, rd); end
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        rf_currcount = 32'd5;
        bus_xfer(1'b0, 4'hC, 32'h0, rdy, rd);
`ifdef TIMER_SNAPSHOT_EN
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL snapshot_hold: got %h want deadbeef", rd); end
`else
        total++; if (rd !== 32'd5) begin bad++; $display("FAIL curr_live: got %h want 5", rd); end
`endif
        bus_xfer(1'b1, 4'hC, 32'h1234_5678, rdy, rd);
        total++; if (rdy !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL curr_write_ack: got rdy=%b rd=%h want 1 0", rdy, rd); end
        bus_xfer(1'b0, 4'h6, 32'h0, rdy, rd);
        total++; if (rd !== 32'd100) begin bad++; $display("FAIL byte_alias: got %h want 64", rd); end
    endtask

    task automatic test_back_to_back();
        logic rdy; logic [31:0] rd;
        bus_xfer(1'b1, 4'h4, 32'h0000_1234, rdy, rd);
        bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 4'h4;
        idle();
        total++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'h1234) begin bad++; $display("FAIL b2b_rd1: got rdy=%b rd=%h want 1 1234", bus_if.bus_ready, bus_if.bus_rdata); end
        bus_if.bus_we = 1'b1; bus_if.bus_wdata = 32'hCAFE_0001;
        idle();
        total++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'h0) begin bad++; $display("FAIL b2b_wr: got rdy=%b rd=%h want 1 0", bus_if.bus_ready, bus_if.bus_rdata); end
        bus_if.bus_we = 1'b0;
        idle();
        total++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_rd2: got rdy=%b rd=%h want 1 cafe0001", bus_if.bus_ready, bus_if.bus_rdata); end
        bus_if.bus_addr = 4'h0;
        idle();
        bus_if.bus_sel = 1'b0;
        total++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'h0) begin bad++; $display("FAIL b2b_rd3: got rdy=%b rd=%h want 1 0", bus_if.bus_ready, bus_if.bus_rdata); end
        idle();
        total++; if (bus_if.bus_ready !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", bus_if.bus_ready); end
    endtask

    task automatic test_reset_mid();
        logic rdy; logic [31:0] rd;
        bus_xfer(1'b1, 4'h0, 32'h4, rdy, rd);
        bus_xfer(1'b1, 4'h4, 32'd123, rdy, rd);
        rf_int = 1'b1;
        idle();
        rf_int = 1'b0;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_setup: got %b want 1", irq); end
        // Reset lands on the edge that would capture a start write.
        bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 4'h0; bus_if.bus_wdata = 32'h1;
        #4 reset = 1'b0;
        idle();
        bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
        total++; if (ro_trig_start !== 1'b0 || bus_if.bus_ready !== 1'b0) begin bad++; $display("FAIL mid_nopulse: got s=%b rdy=%b want 0 0", ro_trig_start, bus_if.bus_ready); end
        total++; if (irq !== 1'b0 || ro_termcount !== TERM_RST) begin bad++; $display("FAIL mid_state: got irq=%b term=%h want 0 %h", irq, ro_termcount, TERM_RST); end
        idle();
        reset = 1'b1;
        rf_status = 1'b0;
        bus_xfer(1'b0, 4'h8, 32'h0, rdy, rd);
        total++; if (rdy !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mid_first_access: got rdy=%b rd=%h want 1 0", rdy, rd); end
        bus_xfer(1'b0, 4'h4, 32'h0, rdy, rd);
        total++; if (rd !== TERM_RST) begin bad++; $display("FAIL mid_term_read: got %h want %h", rd, TERM_RST); end
        // Reset arriving while the pulse is already on the wire kills it at once.
        bus_xfer(1'b1, 4'h0, 32'h1, rdy, rd);
        total++; if (ro_trig_start !== 1'b1) begin bad++; $display("FAIL mid_pulse_pre: got %b want 1", ro_trig_start); end
        #1 reset = 1'b0;
        #1;
        total++; if (ro_trig_start !== 1'b0) begin bad++; $display("FAIL mid_pulse_kill: got %b want 0", ro_trig_start); end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic        m_ie, m_pend, m_prev;
        logic [31:0] m_term, m_snap;
        logic        sel, we, exp_start, exp_halt, ev;
        logic [3:0]  a;
        logic [31:0] wd, exp_rd;
        int          word;
        do_reset();
        m_ie = 1'b0; m_pend = 1'b0; m_prev = 1'b0; m_term = TERM_RST; m_snap = 32'h0;
        for (int n = 0; n < 400; n++) begin
            sel = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) == 1;
            a   = 4'($urandom_range(0, 15));
            wd  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
            rf_int       = ($urandom_range(0, 2) == 0);
            rf_status    = $urandom_range(0, 1) == 1;
            rf_currcount = $urandom;
            bus_if.bus_sel = sel; bus_if.bus_we = we; bus_if.bus_addr = a; bus_if.bus_wdata = wd;
            word = int'(a) / 4;
            exp_rd = 32'h0; exp_start = 1'b0; exp_halt = 1'b0;
            if (sel && !we) begin
                if (word == 0) exp_rd = m_ie ? 32'd4 : 32'd0;
                else if (word == 1) exp_rd = m_term;
                else if (word == 2) exp_rd = (m_pend ? 32'd2 : 32'd0) + (rf_status ? 32'd1 : 32'd0);
`ifdef TIMER_SNAPSHOT_EN
                else exp_rd = m_snap;
                if (word == 2) m_snap = rf_currcount;
`else
                else exp_rd = rf_currcount;
`endif
            end
            if (sel && we) begin
                if (word == 0) begin
                    exp_halt  = wd[1];
                    exp_start = wd[0] && !wd[1];
                    m_ie      = wd[2];
                end
                if (word == 1) m_term = wd;
                if (word == 2 && wd[1]) m_pend = 1'b0;
            end
            ev = rf_int && !m_prev;
            if (ev) m_pend = 1'b1;
            m_prev = rf_int;
            idle();
            total++; if (bus_if.bus_ready !== sel) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus_if.bus_ready, sel); end
            total++; if (bus_if.bus_rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, bus_if.bus_rdata, exp_rd); end
            total++; if (ro_trig_start !== exp_start || ro_trig_halt !== exp_halt) begin bad++; $display("FAIL rnd_trig[%0d]: got %b%b want %b%b", n, ro_trig_start, ro_trig_halt, exp_start, exp_halt); end
            total++; if (ro_termcount !== m_term) begin bad++; $display("FAIL rnd_term[%0d]: got %h want %h", n, ro_termcount, m_term); end
            total++; if (irq !== (m_pend && m_ie)) begin bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_pend && m_ie); end
        end
        bus_if.bus_sel = 1'b0;
        rf_int = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        rf_status = 1'b0;
        rf_currcount = 32'h0;
        rf_int = 1'b0;
        bus_if.bus_sel = 1'b0;
        bus_if.bus_we = 1'b0;
        bus_if.bus_addr = 4'h0;
        bus_if.bus_wdata = 32'h0;
        test_reset();
        test_program_start();
        test_simultaneous();
        test_interrupt();
        test_read_path();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_regif.md
Name: timer_regif

Overview:
- Bus-side register front end for the `timing` counter block: the CPU-facing end of the ro_*/rf_* interface.
- Turns single-beat memory-mapped accesses into the control signals that drive `timing`:
  - ro_trig_start / ro_trig_halt pulses
  - the held ro_termcount
- Returns rf_status / rf_currcount to the bus and converts the rf_int pulse into a sticky, maskable interrupt line for the core.
- Sits between the peripheral bus decoder and the `timing` instance.

Parameters:
- ADDR_W, 4, byte-address width of the local register window (4 word registers at 0x0/0x4/0x8/0xC).
- TERM_RST, 32'hFFFF_FFFF, reset value of the TERMCOUNT register.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- bus_sel  input  1  access request, valid for one cycle per access.
- bus_we  input  1  1 = write, 0 = read; qualified by bus_sel.
- bus_addr  input  ADDR_W  byte address; bits [1:0] ignored.
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data, valid when bus_ready=1.
- bus_ready  output  1  one-cycle acknowledge for every access.
- ro_trig_start  output  1  one-cycle start pulse to the timer.
- ro_trig_halt  output  1  one-cycle halt pulse to the timer.
- ro_termcount  output  32  terminal count held for the timer.
- rf_status  input  1  timer running flag.
- rf_currcount  input  32  live timer count.
- rf_int  input  1  timer terminal-count event (pulse or level; edge-detected here).
- irq  output  1  interrupt to core = pending & ie.

Behaviour:
- Reset (reset=0, async): all outputs 0 except ro_termcount=TERM_RST; ie=0, pending=0, rf_int edge register=0.
- Register map:
  - 0x0 CTRL: write bit0=start, bit1=halt, bit2=ie. Read returns {29'b0, ie, 2'b00}.
  - 0x4 TERMCOUNT: R/W, 32 bits.
  - 0x8 STATUS: read {30'b0, pending, rf_status}; write bit1=1 clears pending (W1C); other bits ignored.
  - 0xC CURRCOUNT: read-only; writes ignored.
- Handshake:
  - bus_ready=1 exactly one cycle after any cycle with bus_sel=1, else 0.
  - bus_rdata registered and valid in that same cycle; 0 when bus_ready=0 or when the access was a write.
  - Back-to-back accesses on consecutive cycles are supported; each gets its own ready.
- Trigger pulses:
  - A CTRL write with start=1 drives ro_trig_start=1 for exactly the cycle after the write. Halt is handled the same way on ro_trig_halt.
  - Both bits set in one write: only ro_trig_halt pulses (halt wins).
  - The ie bit is updated on every CTRL write.
- TERMCOUNT:
  - A write updates ro_termcount on the next edge, whether or not the timer is running.
  - No shadowing; the timer sees the new value immediately.
- Interrupt:
  - The rf_int rising edge (registered previous value) sets pending.
  - W1C and a new edge in the same cycle: pending stays 1 (set wins).
  - irq is combinational from registered pending & ie.
  - Clearing ie masks irq but does not clear pending.
- Unmapped addresses: impossible with ADDR_W=4 and word alignment. If ADDR_W is widened, bits above [3:2] are ignored, so the map aliases.
- Reset mid-access:
  - Any pending bus_ready, pulse or pending bit is dropped.
  - A bus_sel asserted in the first cycle after reset release is serviced normally.

Optional Feature:
- Macro TIMER_SNAPSHOT_EN.
- Defined:
  - A read of STATUS also captures rf_currcount into a 32-bit snapshot register.
  - CURRCOUNT reads return the snapshot, so software gets a coherent status/count pair.
  - Snapshot resets to 0.
- Undefined: CURRCOUNT reads return live rf_currcount sampled on the bus_sel cycle; no snapshot register is built.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → ro_termcount=32'hFFFF_FFFF, irq=0, bus_ready=0, both triggers 0.
- Program and start: write 0x4 ← 32'd100, then write 0x0 ← 32'h5 → ro_termcount=100 one cycle after the first write; ro_trig_start high exactly 1 cycle; ie=1. Read 0x0 → 32'h4.
- Simultaneous start+halt: write 0x0 ← 32'h3 → ro_trig_halt pulses 1 cycle, ro_trig_start stays 0.
- Interrupt, mask and W1C:
  - With ie=1, pulse rf_int 1 cycle → pending=1, irq=1.
  - Read 0x8 with rf_status=1 → 32'h3.
  - Write 0x0 ← 0 → irq=0, pending still set.
  - Write 0x8 ← 32'h2 → pending=0.
  - Repeat the W1C in the same cycle as an rf_int edge → pending remains 1.
- Read path: rf_currcount=32'hDEAD_BEEF, read 0xC → bus_ready and bus_rdata=32'hDEAD_BEEF exactly 1 cycle later. With TIMER_SNAPSHOT_EN, read 0x8, change rf_currcount to 5, read 0xC → still 32'hDEAD_BEEF.
- Reset mid-operation: assert reset in the cycle a start pulse is due → no ro_trig_start pulse, pending=0, ro_termcount=TERM_RST.
